// File: rtl/xorshift_plus_gen_if.sv
// ---------------------------------------------------------------------------
// xorshift_plus_gen_if
// Output handshake bundle of the xorshift128+ generator.
//   out_data  : current random word (producer -> consumer)
//   out_valid : out_data is a deliverable word (producer -> consumer)
//   out_ready : consumer accepts out_data this cycle (consumer -> producer)
// master modport is the generator side, slave modport the consumer side.
// ---------------------------------------------------------------------------
interface xorshift_plus_gen_if #(
  parameter int WIDTH = 64
) ();
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/xorshift_plus_gen.sv
// ---------------------------------------------------------------------------
// xorshift_plus_gen
// Parametrised xorshift128+ word generator with warm-up discard, zero-seed
// protection, valid/ready output and a saturating delivered-word counter.
//
// Ports:
//   clk         : clock, all state updates on the rising edge
//   rst         : asynchronous, active-high reset
//   seed0/seed1 : seed values for state0/state1
//   seed_load   : load seeds this cycle (priority over everything but rst)
//   out_if      : master side of the output handshake (out_data, out_valid,
//                 out_ready)
//   busy        : high while warm-up advances are being discarded
//   draw_count  : words delivered since the last load, saturating
// ---------------------------------------------------------------------------
module xorshift_plus_gen #(
  parameter int          WIDTH    = 64,
  parameter int          SHIFT_A  = 23,
  parameter int          SHIFT_B  = 18,
  parameter int          SHIFT_C  = 5,
  parameter int          WARMUP   = 16,
  parameter logic [63:0] ZERO_SUB = 64'h9E3779B97F4A7C15,
  parameter int          CNT_W    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       seed0,
  input  logic [WIDTH-1:0]       seed1,
  input  logic                   seed_load,
  xorshift_plus_gen_if.master    out_if,
  output logic                   busy,
  output logic [CNT_W-1:0]       draw_count
);

  // Warm-up counter only needs to reach WARMUP-1; keep at least one bit so
  // the WARMUP = 0 build still elaborates (the counter is then unused logic).
  localparam int             WU_W    = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [WU_W-1:0] WU_LAST = WU_W'((WARMUP > 0) ? (WARMUP - 1) : 0);
  localparam logic [WIDTH-1:0] ZSUB  = WIDTH'(ZERO_SUB);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WARM = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  // One xorshift128+ advance; returns {state0', state1'}.
  function automatic logic [2*WIDTH-1:0] xs_step(
    input logic [WIDTH-1:0] st0,
    input logic [WIDTH-1:0] st1
  );
    logic [WIDTH-1:0] s0;
    logic [WIDTH-1:0] s1;
    s1 = st0;
    s0 = st1;
    s1 = s1 ^ (s1 << SHIFT_A);
    return {s0, s1 ^ s0 ^ (s1 >> SHIFT_B) ^ (s0 >> SHIFT_C)};
  endfunction

  // Saturating increment: holds at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : (c + 1'b1);
  endfunction

  state_t           state_q;
  state_t           state_d;
  logic [WU_W-1:0]  warm_cnt_q;
  logic [WIDTH-1:0] st0_p0;
  logic [WIDTH-1:0] st1_p0;
  logic [WIDTH-1:0] data_p0;
  logic [CNT_W-1:0] cnt_p0;

  logic             adv_en;
  logic             cnt_en;
  logic             warm_en;
  logic             valid_c;
  logic             busy_c;

  logic [2*WIDTH-1:0] nxt;
  logic [WIDTH-1:0]   nxt0;
  logic [WIDTH-1:0]   nxt1;
  logic               seeds_zero;
  logic [WIDTH-1:0]   ld0;
  logic [WIDTH-1:0]   ld1;

  assign nxt        = xs_step(st0_p0, st1_p0);
  assign nxt0       = nxt[2*WIDTH-1:WIDTH];
  assign nxt1       = nxt[WIDTH-1:0];

  // An all-zero state is a fixed point of the step, so it is never loaded.
  assign seeds_zero = ~(|seed0) & ~(|seed1);
  assign ld0        = seeds_zero ? ZSUB : seed0;
  assign ld1        = seeds_zero ? '0   : seed1;

  // Control: FSM register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Control: next state and per-cycle enables; a load overrides everything.
  always_comb begin
    state_d = state_q;
    adv_en  = 1'b0;
    cnt_en  = 1'b0;
    warm_en = 1'b0;
    valid_c = 1'b0;
    busy_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end
      S_WARM: begin
        busy_c  = 1'b1;
        adv_en  = 1'b1;
        warm_en = 1'b1;
        if (warm_cnt_q == WU_LAST) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        valid_c = 1'b1;
        adv_en  = out_if.out_ready;
        cnt_en  = out_if.out_ready;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (seed_load) begin
      adv_en  = 1'b0;
      cnt_en  = 1'b0;
      warm_en = 1'b0;
      state_d = (WARMUP > 0) ? S_WARM : S_RUN;
    end
  end

  // Control: warm-up advance counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      warm_cnt_q <= '0;
    end else if (seed_load) begin
      warm_cnt_q <= '0;
    end else if (warm_en) begin
      warm_cnt_q <= warm_cnt_q + 1'b1;
    end
  end

  // Stage p0: generator state, registered output word and delivered count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st0_p0  <= '0;
      st1_p0  <= '0;
      data_p0 <= '0;
      cnt_p0  <= '0;
    end else if (seed_load) begin
      st0_p0  <= ld0;
      st1_p0  <= ld1;
      data_p0 <= ld0 + ld1;
      cnt_p0  <= '0;
    end else begin
      if (adv_en) begin
        st0_p0  <= nxt0;
        st1_p0  <= nxt1;
        data_p0 <= nxt0 + nxt1;
      end
      if (cnt_en) begin
        cnt_p0 <= sat_inc(cnt_p0);
      end
    end
  end

  assign out_if.out_data  = data_p0;
  assign out_if.out_valid = valid_c;
  assign busy             = busy_c;
  assign draw_count       = cnt_p0;

endmodule
